dot_product_scheduler: RTL and testbench
========================================

// Module: dot_product_scheduler
// PURPOSE
//  Shares one pipelined 3-D dot-product unit (3 chained fma64 stages, fixed latency) among NUM_REQ requesters.
//  Round-robin arbitration; one operand pair issued per cycle; each result is returned with its requester id and tag.
//  Back-pressure is handled by gating the unit's proceed input.
//  Sits between the quadric-intersector stages (ray/coeff producers) and the shared dot-product datapath.
// PARAMETERS
//  NUM_REQ   4   number of requesters (>=2)
//  PIPE_LAT  12  cycles from operand issue to dp_out; proceed-gated
//  TAG_W     4   width of per-request tag, returned unchanged
// PORTS
//  clk         in   1                 clock, rising edge
//  reset       in   1                 asynchronous, active-high
//  req_valid   in   NUM_REQ           request valid per requester
//  req_ready   out  NUM_REQ           request accepted this cycle (one-hot or zero)
//  req_left    in   NUM_REQ x Vec3    left operand, 3 x 64-bit IEEE 754
//  req_right   in   NUM_REQ x Vec3    right operand
//  req_tag     in   NUM_REQ x TAG_W   opaque tag
//  dp_left     out  Vec3              to dot-product unit, left
//  dp_right    out  Vec3              to dot-product unit, right
//  dp_proceed  out  1                 to dot-product unit, advance enable
//  dp_out      in   UCBFloat (65)     from dot-product unit, recoded result
//  rsp_valid   out  1                 result valid
//  rsp_ready   in   1                 consumer accepts result
//  rsp_id      out  $clog2(NUM_REQ)   requester index of result
//  rsp_tag     out  TAG_W             tag of result
//  rsp_data    out  UCBFloat (65)     = dp_out
//  flush       in   1                 level; stop issuing and drain
//  flush_done  out  1                 drained, no work in flight
//  busy        out  1                 in-flight count != 0
// BEHAVIOUR
//  Reset: req_ready=0, dp_proceed=1, rsp_valid=0, flush_done=0, busy=0.
//   Shadow pipe is cleared. RR pointer=NUM_REQ-1, so req 0 has first priority.
//   The FSM goes to IDLE. In-flight work is discarded, with no responses for it.
//  Shadow pipe: PIPE_LAT stages of {valid,id,tag}; shifts only when dp_proceed=1.
//   Stage 0 is loaded with the grant, or valid=0 (a bubble) if nothing is granted.
//  rsp_valid/rsp_id/rsp_tag = last shadow stage; rsp_data = dp_out (combinational).
//  dp_proceed = !(rsp_valid && !rsp_ready). A stall freezes both pipes and the issue slot.
//  Issue allowed when: dp_proceed && state != DRAIN/DONE && inflight < PIPE_LAT.
//   Grant goes to the first req_valid after the RR pointer (wrapping).
//   req_ready[g]=1 for that cycle only; the RR pointer updates to g.
//   dp_left/dp_right = operands of g; otherwise they hold 0.
//  Requests must stay stable until req_ready; the scheduler never drops an accepted request.
//  inflight counter (0..PIPE_LAT): +1 on issue, -1 on rsp_valid&&rsp_ready, net 0 if both; never over/underflows.
//  FSM:
//   IDLE : inflight==0 and no issue. Issue->RUN. flush->DONE.
//   RUN  : issuing/in flight. inflight goes 0 with no issue->IDLE. flush->DRAIN.
//   DRAIN: no issue; responses continue. inflight==0->DONE.
//   DONE : flush_done=1. flush deasserted->IDLE.
//  flush in the same cycle as a would-be grant: the flush wins, there is no grant.
//  Response fire and new issue in the same cycle are both legal; throughput is 1/cycle.
//  Bubbles never produce rsp_valid; results keep issue order (in-order pipeline).
// TESTING
//  1) Reset, then req0 valid, left=(1,2,3), right=(4,5,6).
//     -> req_ready[0]=1 at cycle 0; rsp_valid at cycle PIPE_LAT, rsp_data=recode(32.0), rsp_id=0.
//  2) All 4 requesters valid continuously, rsp_ready=1.
//     -> grants 0,1,2,3,0,... one per cycle; responses come back in the same order, back-to-back.
//  3) rsp_ready=0 for 5 cycles while rsp_valid=1.
//     -> dp_proceed=0, no grants, rsp fields stable; the pipe resumes intact on release, no loss or duplication.
//  4) flush asserted with 3 in flight.
//     -> no further req_ready; 3 responses; then flush_done=1; flush low -> IDLE, issue resumes.
//  5) reset asserted mid-stream with 6 in flight.
//     -> rsp_valid=0 immediately (async), busy=0; the first grant after release goes to req0.
//  6) Only req2 valid, with tags 0..15.
//     -> req2 granted every cycle; rsp_tag returns 0..15 in order, rsp_id=2.

Source files
------------

// File: rtl/dot_product_scheduler_if.sv
// dot_product_scheduler_if: requester, dot-product unit and response signals of the scheduler
interface dot_product_scheduler_if #(
    parameter int NUM_REQ = 4,
    parameter int TAG_W   = 4
);
    localparam int ID_W = $clog2(NUM_REQ);
    logic [NUM_REQ-1:0]            req_valid;
    logic [NUM_REQ-1:0]            req_ready;
    logic [NUM_REQ-1:0][191:0]     req_left;
    logic [NUM_REQ-1:0][191:0]     req_right;
    logic [NUM_REQ-1:0][TAG_W-1:0] req_tag;
    logic [191:0]                  dp_left;
    logic [191:0]                  dp_right;
    logic                          dp_proceed;
    logic [64:0]                   dp_out;
    logic                          rsp_valid;
    logic                          rsp_ready;
    logic [ID_W-1:0]               rsp_id;
    logic [TAG_W-1:0]              rsp_tag;
    logic [64:0]                   rsp_data;
    logic                          flush;
    logic                          flush_done;
    logic                          busy;
    modport master (
        output req_valid, req_left, req_right, req_tag, dp_out, rsp_ready, flush,
        input  req_ready, dp_left, dp_right, dp_proceed, rsp_valid, rsp_id, rsp_tag, rsp_data,
               flush_done, busy
    );
    modport slave (
        input  req_valid, req_left, req_right, req_tag, dp_out, rsp_ready, flush,
        output req_ready, dp_left, dp_right, dp_proceed, rsp_valid, rsp_id, rsp_tag, rsp_data,
               flush_done, busy
    );
endinterface

// File: rtl/dot_product_scheduler.sv
// dot_product_scheduler: round-robin sharing of one fixed-latency dot-product unit,
// tracking {valid,id,tag} in a shadow pipe that advances in lockstep with the unit.
module dot_product_scheduler #(
    parameter int NUM_REQ  = 4,
    parameter int PIPE_LAT = 12,
    parameter int TAG_W    = 4
) (
    input logic clk,
    input logic reset,
    dot_product_scheduler_if.slave bus
);
    localparam int ID_W  = $clog2(NUM_REQ);
    localparam int CNT_W = $clog2(PIPE_LAT + 1);
    typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_t;
    state_t state, state_nxt;
    logic [PIPE_LAT-1:0] sh_valid;
    logic [ID_W-1:0]     sh_id  [PIPE_LAT];
    logic [TAG_W-1:0]    sh_tag [PIPE_LAT];
    logic [ID_W-1:0]     ptr, gnt;
    logic [CNT_W-1:0]    inflight;
    logic                found, issue, fire, proceed;
    always_comb begin
        found = 1'b0;
        gnt = ptr;
        for (int i = 1; i <= NUM_REQ; i++) begin
            if (!found && bus.req_valid[ID_W'((int'(ptr) + i) % NUM_REQ)]) begin
                found = 1'b1;
                gnt = ID_W'((int'(ptr) + i) % NUM_REQ);
            end
        end
    end
    // a stall freezes the unit, the shadow pipe and the issue slot together
    assign proceed        = !(sh_valid[PIPE_LAT-1] && !bus.rsp_ready);
    assign fire           = sh_valid[PIPE_LAT-1] && bus.rsp_ready;
    assign issue          = found && proceed && !reset && !bus.flush &&
                            (state == IDLE || state == RUN) && inflight < CNT_W'(PIPE_LAT);
    assign bus.req_ready  = {{(NUM_REQ-1){1'b0}}, issue} << gnt;
    assign bus.dp_left    = issue ? bus.req_left[gnt] : '0;
    assign bus.dp_right   = issue ? bus.req_right[gnt] : '0;
    assign bus.dp_proceed = proceed;
    assign bus.rsp_valid  = sh_valid[PIPE_LAT-1];
    assign bus.rsp_id     = sh_id[PIPE_LAT-1];
    assign bus.rsp_tag    = sh_tag[PIPE_LAT-1];
    assign bus.rsp_data   = bus.dp_out;
    assign bus.flush_done = state == DONE;
    assign bus.busy       = inflight != '0;
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    state_nxt = bus.flush ? DONE : (issue ? RUN : IDLE);
            RUN:     state_nxt = bus.flush ? DRAIN : ((inflight == '0 && !issue) ? IDLE : RUN);
            DRAIN:   state_nxt = inflight == '0 ? DONE : DRAIN;
            DONE:    state_nxt = bus.flush ? DONE : IDLE;
            default: state_nxt = IDLE;
        endcase
    end
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state    <= IDLE;
            ptr      <= ID_W'(NUM_REQ - 1);
            inflight <= '0;
            sh_valid <= '0;
            for (int i = 0; i < PIPE_LAT; i++) begin
                sh_id[i]  <= '0;
                sh_tag[i] <= '0;
            end
        end else begin
            state    <= state_nxt;
            inflight <= inflight + CNT_W'(issue) - CNT_W'(fire);
            if (issue) ptr <= gnt;
            if (proceed) begin
                sh_valid  <= {sh_valid[PIPE_LAT-2:0], issue};
                sh_id[0]  <= gnt;
                sh_tag[0] <= bus.req_tag[gnt];
                for (int i = 1; i < PIPE_LAT; i++) begin
                    sh_id[i]  <= sh_id[i-1];
                    sh_tag[i] <= sh_tag[i-1];
                end
            end
        end
    end
endmodule

// File: tb/tb_dot_product_scheduler.sv
// tb_dot_product_scheduler: directed vectors with a grant/response scoreboard and a
// behavioural fixed-latency dot-product unit behind the scheduler.
module tb_dot_product_scheduler;
    localparam int NUM_REQ = 4, PIPE_LAT = 12, TAG_W = 4;
    typedef struct { logic [191:0] l; logic [191:0] r; logic [TAG_W-1:0] tag; } item_t;
    typedef struct { int id; logic [TAG_W-1:0] tag; logic [64:0] data; } rsp_t;
    logic clk = 0, reset = 0;
    always #5 clk = ~clk;
    dot_product_scheduler_if #(.NUM_REQ(NUM_REQ), .TAG_W(TAG_W)) ifc ();
    dot_product_scheduler #(.NUM_REQ(NUM_REQ), .PIPE_LAT(PIPE_LAT), .TAG_W(TAG_W)) dut (
        .clk(clk), .reset(reset), .bus(ifc));
    item_t rq [NUM_REQ][$];
    int    eg [$];
    rsp_t  er [$];
    int checks = 0, failures = 0, rsp_cnt = 0, gnt_cnt = 0, base = 0, gb = 0;
    logic [NUM_REQ-1:0] g_seen;
    rsp_t mon_e;
    logic [TAG_W-1:0] cap_tag;
    logic [1:0] cap_id;
    logic [64:0] cap_data;
    task automatic check(string name, logic [255:0] act, logic [255:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h want %0h", name, act, exp);
        end
    endtask
    function automatic logic [191:0] vec(real x, real y, real z);
        return {$realtobits(z), $realtobits(y), $realtobits(x)};
    endfunction
    function automatic real dot(logic [191:0] a, logic [191:0] b);
        return $bitstoreal(a[63:0]) * $bitstoreal(b[63:0]) +
               $bitstoreal(a[127:64]) * $bitstoreal(b[127:64]) +
               $bitstoreal(a[191:128]) * $bitstoreal(b[191:128]);
    endfunction
    // recoded 65-bit form of a normal or zero double
    function automatic logic [64:0] rec(real v);
        logic [63:0] b;
        logic [11:0] e;
        b = $realtobits(v);
        if (b[62:0] == '0) return {b[63], 64'd0};
        e = {1'b0, b[62:52]} + 12'd1025;
        return {b[63], e, b[51:0]};
    endfunction
    logic [64:0] fu [PIPE_LAT];
    always @(posedge clk or posedge reset)
        if (reset) for (int i = 0; i < PIPE_LAT; i++) fu[i] <= '0;
        else if (ifc.dp_proceed) begin
            fu[0] <= rec(dot(ifc.dp_left, ifc.dp_right));
            for (int i = 1; i < PIPE_LAT; i++) fu[i] <= fu[i-1];
        end
    assign ifc.dp_out = fu[PIPE_LAT-1];
    function automatic void drive();
        for (int r = 0; r < NUM_REQ; r++) begin
            ifc.req_valid[r] = rq[r].size() > 0;
            ifc.req_left[r]  = rq[r].size() > 0 ? rq[r][0].l : '0;
            ifc.req_right[r] = rq[r].size() > 0 ? rq[r][0].r : '0;
            ifc.req_tag[r]   = rq[r].size() > 0 ? rq[r][0].tag : '0;
        end
    endfunction
    task automatic issue(int r, real lx, real ly, real lz, real rx, real ry, real rz,
                         logic [TAG_W-1:0] tag);
        item_t it;
        rsp_t e;
        it.l = vec(lx, ly, lz);
        it.r = vec(rx, ry, rz);
        it.tag = tag;
        rq[r].push_back(it);
        eg.push_back(r);
        e.id = r;
        e.tag = tag;
        e.data = rec(lx * rx + ly * ry + lz * rz);
        er.push_back(e);
    endtask
    task automatic issue_n(int r, int n, logic [TAG_W-1:0] tag);
        issue(r, real'(n + 1), real'(r + 1), 2.0, 2.0, 3.0, real'(n), tag);
    endtask
    task automatic tick();
        @(posedge clk);
        #2;
    endtask
    task automatic wait_rsp(int n, int budget, string name);
        for (int k = 0; k < budget && rsp_cnt < n; k++) tick();
        check(name, rsp_cnt >= n, 1);
    endtask
    task automatic wait_gnt(int n, int budget, string name);
        for (int k = 0; k < budget && gnt_cnt < n; k++) tick();
        check(name, gnt_cnt >= n, 1);
    endtask
    task automatic do_reset();
        reset = 1;
        for (int r = 0; r < NUM_REQ; r++) rq[r].delete();
        eg.delete();
        er.delete();
        drive();
        tick();
        tick();
        reset = 0;
    endtask
    // requests are retired just after the edge that granted them
    always begin
        @(negedge clk);
        g_seen = ifc.req_ready;
        @(posedge clk);
        #1;
        for (int r = 0; r < NUM_REQ; r++)
            if (g_seen[r] && rq[r].size() > 0) void'(rq[r].pop_front());
        drive();
    end
    always @(negedge clk) if (!reset) begin
        if (ifc.req_ready != '0) begin
            gnt_cnt++;
            if (eg.size() == 0) check("grant_unexpected", ifc.req_ready, 0);
            else check("grant", ifc.req_ready, 256'(1) << eg.pop_front());
        end
        if (ifc.rsp_valid && ifc.rsp_ready) begin
            rsp_cnt++;
            if (er.size() == 0) check("rsp_unexpected", ifc.rsp_valid, 0);
            else begin
                mon_e = er.pop_front();
                check("rsp_id", ifc.rsp_id, mon_e.id);
                check("rsp_tag", ifc.rsp_tag, mon_e.tag);
                check("rsp_data", ifc.rsp_data, mon_e.data);
            end
        end
    end
    initial begin
        #200000;
        $display("FAIL timeout: checks=%0d", checks);
        $fatal(1, "timeout");
    end
    initial begin
        ifc.rsp_ready = 1;
        ifc.flush = 0;
        drive();
        #1 reset = 1;
        #1;
        check("rst_req_ready", ifc.req_ready, 0);
        check("rst_dp_proceed", ifc.dp_proceed, 1);
        check("rst_rsp_valid", ifc.rsp_valid, 0);
        check("rst_flush_done", ifc.flush_done, 0);
        check("rst_busy", ifc.busy, 0);
        tick();
        reset = 0;
        issue(0, 1.0, 2.0, 3.0, 4.0, 5.0, 6.0, 4'h5);
        drive();
        @(negedge clk);
        check("t1_grant0", ifc.req_ready, 1);
        repeat (PIPE_LAT - 1) @(negedge clk);
        check("t1_rsp_early", ifc.rsp_valid, 0);
        @(negedge clk);
        check("t1_rsp_valid", ifc.rsp_valid, 1);
        check("t1_data_32", ifc.rsp_data, {1'b0, 12'h805, 52'd0});
        check("t1_id", ifc.rsp_id, 0);
        tick();
        do_reset();
        base = rsp_cnt;
        for (int n = 0; n < 2; n++)
            for (int r = 0; r < NUM_REQ; r++) issue_n(r, n, TAG_W'(n * 4 + r));
        drive();
        wait_rsp(base + 8, 60, "t2_done");
        do_reset();
        base = rsp_cnt;
        for (int n = 0; n < 20; n++) issue_n(1, n, TAG_W'(n));
        drive();
        wait_rsp(base + 3, 40, "t3_prefill");
        ifc.rsp_ready = 0;
        @(negedge clk);
        cap_id = ifc.rsp_id;
        cap_tag = ifc.rsp_tag;
        cap_data = ifc.rsp_data;
        check("t3_stall_valid", ifc.rsp_valid, 1);
        check("t3_stall_proceed", ifc.dp_proceed, 0);
        check("t3_stall_head_tag", cap_tag, er[0].tag);
        repeat (4) begin
            @(negedge clk);
            check("t3_stall_proceed", ifc.dp_proceed, 0);
            check("t3_stall_no_grant", ifc.req_ready, 0);
            check("t3_stall_id", ifc.rsp_id, cap_id);
            check("t3_stall_tag", ifc.rsp_tag, cap_tag);
            check("t3_stall_data", ifc.rsp_data, cap_data);
        end
        tick();
        ifc.rsp_ready = 1;
        wait_rsp(base + 20, 60, "t3_drain");
        do_reset();
        base = rsp_cnt;
        gb = gnt_cnt;
        for (int r = 0; r < 3; r++) issue_n(r, r + 7, TAG_W'(r + 8));
        drive();
        wait_gnt(gb + 3, 10, "t4_issue3");
        ifc.flush = 1;
        issue_n(3, 9, 4'hb);
        drive();
        for (int k = 0; k < 40 && !ifc.flush_done; k++) begin
            @(negedge clk);
            check("t4_no_grant", ifc.req_ready, 0);
        end
        check("t4_flush_done", ifc.flush_done, 1);
        check("t4_rsp3", rsp_cnt - base, 3);
        check("t4_busy", ifc.busy, 0);
        tick();
        tick();
        check("t4_done_hold", ifc.flush_done, 1);
        ifc.flush = 0;
        tick();
        check("t4_done_clear", ifc.flush_done, 0);
        wait_rsp(base + 4, 30, "t4_resume");
        do_reset();
        gb = gnt_cnt;
        for (int n = 0; n < 10; n++) issue_n(2, n, TAG_W'(n));
        drive();
        wait_gnt(gb + 6, 20, "t5_six");
        check("t5_busy_pre", ifc.busy, 1);
        reset = 1;
        #1;
        check("t5_rsp_valid", ifc.rsp_valid, 0);
        check("t5_busy", ifc.busy, 0);
        check("t5_req_ready", ifc.req_ready, 0);
        do_reset();
        base = rsp_cnt;
        issue_n(0, 3, 4'h1);
        issue_n(3, 4, 4'h2);
        drive();
        @(negedge clk);
        check("t5_first_grant", ifc.req_ready, 1);
        wait_rsp(base + 2, 30, "t5_after");
        do_reset();
        base = rsp_cnt;
        for (int n = 0; n < 16; n++) issue_n(2, n, TAG_W'(n));
        drive();
        wait_rsp(base + 16, 80, "t6_done");
        check("queues_empty", eg.size() + er.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
